// File: rtl/button_debouncer_pkg.sv
// Shared constants for the push-button game modules: button polarity and the
// default debounce interval derived from the system clock frequency.
package button_debouncer_pkg;

    // Active-low buttons: a released pin reads high.
    localparam logic BTN_RELEASED = 1'b1;
    localparam logic BTN_PRESSED  = 1'b0;

    // System clock shared by all game modules.
    localparam int CLOCK_FREQ  = 12_000_000;
    localparam int DEBOUNCE_MS = 10;

    // Cycles a new input level must persist before it is believed.
    localparam int DEFAULT_DEBOUNCE_COUNT = (CLOCK_FREQ / 1000) * DEBOUNCE_MS;

    // Counter width able to hold 0..debounce_count.
    function automatic int debounce_cnt_width(input int debounce_count);
        return $clog2(debounce_count + 1);
    endfunction

endpackage

// File: rtl/button_debouncer_channel.sv
// Single-bit debouncer: two-flop synchroniser, persistence counter, stable
// level register and one-cycle press/release pulses. All outputs registered.
module debounce_channel
    import button_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_COUNT = DEFAULT_DEBOUNCE_COUNT
) (
    input  logic clk,
    input  logic rst_in,
    input  logic btn_in,
    output logic level_out,
    output logic press_out,
    output logic release_out
);

    localparam int               CNT_W    = debounce_cnt_width(DEBOUNCE_COUNT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_COUNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;
    logic             r_press;
    logic             r_release;

    // Synchronise the raw pin, then accept a new level only after it has held
    // for DEBOUNCE_COUNT consecutive cycles; any return to the old level
    // restarts the count, so short glitches never reach the outputs.
    always_ff @(posedge clk) begin
        if (rst_in) begin
            // NOTE: non-blocking assignments keep every register sampling the
            // pre-edge values, which is what makes sync1->sync2 a real two-stage
            // pipeline rather than a single flop.
            r_sync1   <= BTN_RELEASED;
            r_sync2   <= BTN_RELEASED;
            r_stable  <= BTN_RELEASED;
            r_cnt     <= '0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_sync1   <= btn_in;
            r_sync2   <= r_sync1;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_stable  <= r_sync2;
                r_cnt     <= '0;
                r_press   <= (r_sync2 == BTN_PRESSED);
                r_release <= (r_sync2 == BTN_RELEASED);
            end else begin
                r_cnt <= r_cnt + CNT_ONE;
            end
        end
    end

    assign level_out   = r_stable;
    assign press_out   = r_press;
    assign release_out = r_release;

endmodule

// File: rtl/button_debouncer.sv
// N-channel button debouncer: one independent debounce_channel per pin.
// Simultaneous transitions are reported together; ties are resolved downstream.
module button_debouncer
    import button_debouncer_pkg::*;
#(
    parameter int N_BUTTONS      = 2,
    parameter int DEBOUNCE_COUNT = DEFAULT_DEBOUNCE_COUNT
) (
    input  logic                 clk,
    input  logic                 rst_in,
    input  logic [N_BUTTONS-1:0] btn_in,
    output logic [N_BUTTONS-1:0] btn_level_out,
    output logic [N_BUTTONS-1:0] press_out,
    output logic [N_BUTTONS-1:0] release_out
);

    // One debouncer per button; channels share nothing but clock and reset.
    for (genvar k = 0; k < N_BUTTONS; k++) begin : g_channel
        debounce_channel #(
            .DEBOUNCE_COUNT(DEBOUNCE_COUNT)
        ) u_channel (
            .clk        (clk),
            .rst_in     (rst_in),
            .btn_in     (btn_in[k]),
            .level_out  (btn_level_out[k]),
            .press_out  (press_out[k]),
            .release_out(release_out[k])
        );
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with DEBOUNCE_COUNT = 8, N_BUTTONS = 2.
// Inputs change 1 ns after a rising edge; outputs are observed at that point,
// so an input driven after edge P is first sampled at edge P+1 and, if held,
// appears on the outputs after the 10th following edge.
module tb_button_debouncer;

    localparam int N  = 2;
    localparam int DC = 8;

    logic         clk = 1'b0;
    logic         rst_in;
    logic [N-1:0] btn_in;
    logic [N-1:0] btn_level_out;
    logic [N-1:0] press_out;
    logic [N-1:0] release_out;

    int checks   = 0;
    int failures = 0;

    // {level, press, release}
    logic [3*N-1:0] obs;
    logic [3*N-1:0] exp_v;

    button_debouncer #(
        .N_BUTTONS     (N),
        .DEBOUNCE_COUNT(DC)
    ) dut (
        .clk          (clk),
        .rst_in       (rst_in),
        .btn_in       (btn_in),
        .btn_level_out(btn_level_out),
        .press_out    (press_out),
        .release_out  (release_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        obs = {btn_level_out, press_out, release_out};
    endtask

    // Reset holds everything released regardless of the pins; afterwards idle
    // released pins produce no activity.
    task automatic test_reset();
        rst_in = 1'b1;
        btn_in = 2'b00;
        for (int i = 1; i <= 3; i++) begin
            tick();
            exp_v = {2'b11, 2'b00, 2'b00};
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL reset cyc%0d: got lvl/prs/rel=%b required %b", i, obs, exp_v);
            end
        end
        rst_in = 1'b0;
        btn_in = 2'b11;
        for (int i = 1; i <= 50; i++) begin
            tick();
            exp_v = {2'b11, 2'b00, 2'b00};
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL idle cyc%0d: got lvl/prs/rel=%b required %b", i, obs, exp_v);
            end
        end
    endtask

    // Channel 0 press then release, channel 1 untouched; exact-cycle latency.
    task automatic test_clean_press();
        btn_in = 2'b10;
        for (int i = 1; i <= 11; i++) begin
            tick();
            if (i < 10)       exp_v = {2'b11, 2'b00, 2'b00};
            else if (i == 10) exp_v = {2'b10, 2'b01, 2'b00};
            else              exp_v = {2'b10, 2'b00, 2'b00};
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL press0 cyc%0d: got lvl/prs/rel=%b required %b", i, obs, exp_v);
            end
        end
        btn_in = 2'b11;
        for (int i = 1; i <= 11; i++) begin
            tick();
            if (i < 10)       exp_v = {2'b10, 2'b00, 2'b00};
            else if (i == 10) exp_v = {2'b11, 2'b00, 2'b01};
            else              exp_v = {2'b11, 2'b00, 2'b00};
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL release0 cyc%0d: got lvl/prs/rel=%b required %b", i, obs, exp_v);
            end
        end
    endtask

    // Low glitches of 1, 4 and 7 cycles are swallowed; an 8-cycle low is not.
    task automatic test_bounce();
        int seg_len [6] = '{1, 3, 4, 3, 7, 3};
        logic seg_val [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        int n = 0;
        for (int s = 0; s < 6; s++) begin
            btn_in = {1'b1, seg_val[s]};
            for (int i = 0; i < seg_len[s]; i++) begin
                tick();
                n++;
                exp_v = {2'b11, 2'b00, 2'b00};
                checks++;
                if (obs !== exp_v) begin
                    failures++;
                    $display("FAIL bounce cyc%0d: got lvl/prs/rel=%b required %b", n, obs, exp_v);
                end
            end
        end
        // 8 cycles low then high again: accepted press, later a release.
        btn_in = 2'b10;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 8) btn_in = 2'b11;
            if (i < 10)       exp_v = {2'b11, 2'b00, 2'b00};
            else if (i == 10) exp_v = {2'b10, 2'b01, 2'b00};
            else if (i < 18)  exp_v = {2'b10, 2'b00, 2'b00};
            else if (i == 18) exp_v = {2'b11, 2'b00, 2'b01};
            else              exp_v = {2'b11, 2'b00, 2'b00};
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL bounce8 cyc%0d: got lvl/prs/rel=%b required %b", i, obs, exp_v);
            end
        end
    endtask

    // Both channels pressed on the same edge report together.
    task automatic test_simultaneous();
        btn_in = 2'b00;
        for (int i = 1; i <= 11; i++) begin
            tick();
            if (i < 10)       exp_v = {2'b11, 2'b00, 2'b00};
            else if (i == 10) exp_v = {2'b00, 2'b11, 2'b00};
            else              exp_v = {2'b00, 2'b00, 2'b00};
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL simul cyc%0d: got lvl/prs/rel=%b required %b", i, obs, exp_v);
            end
        end
    endtask

    // Channel 1 released from the pressed state; channel 0 stays pressed.
    task automatic test_release();
        btn_in = 2'b10;
        for (int i = 1; i <= 11; i++) begin
            tick();
            if (i < 10)       exp_v = {2'b00, 2'b00, 2'b00};
            else if (i == 10) exp_v = {2'b10, 2'b00, 2'b10};
            else              exp_v = {2'b10, 2'b00, 2'b00};
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL release1 cyc%0d: got lvl/prs/rel=%b required %b", i, obs, exp_v);
            end
        end
    endtask

    // Reset while channel 1 counts (cnt=5) and channel 0 is pressed: both
    // return to released silently, then the held pins give a fresh press a
    // full 10 edges after the reset edge.
    task automatic test_reset_mid_count();
        btn_in = 2'b00;
        for (int i = 1; i <= 7; i++) begin
            tick();
            exp_v = {2'b10, 2'b00, 2'b00};
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL midcnt cyc%0d: got lvl/prs/rel=%b required %b", i, obs, exp_v);
            end
        end
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        exp_v = {2'b11, 2'b00, 2'b00};
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL midcnt_rst: got lvl/prs/rel=%b required %b", obs, exp_v);
        end
        for (int i = 1; i <= 11; i++) begin
            tick();
            if (i < 10)       exp_v = {2'b11, 2'b00, 2'b00};
            else if (i == 10) exp_v = {2'b00, 2'b11, 2'b00};
            else              exp_v = {2'b00, 2'b00, 2'b00};
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL post_rst cyc%0d: got lvl/prs/rel=%b required %b", i, obs, exp_v);
            end
        end
    endtask

    initial begin
        rst_in = 1'b1;
        btn_in = 2'b00;
        test_reset();
        test_clean_press();
        test_bounce();
        test_simultaneous();
        test_release();
        test_reset_mid_count();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
